fetch_unit: RTL

Instruction fetch front-end for the RV32I `DATAPATH`. It owns the fetch PC, issues word requests to instruction memory over a request/grant, in-order-response interface, and buffers the returned words in a small FIFO. It presents the buffered words to decode with a valid/ready handshake. On a branch/jump redirect it flushes the buffer and discards responses already in flight.

---
 rtl/fetch_pkg.sv | 28 ++
 rtl/fetch_fifo.sv | 66 ++++++
 rtl/fetch_unit.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch front-end.
package fetch_pkg;

    localparam int unsigned XLEN    = 32;
    localparam int unsigned INSTR_W = 32;
    localparam int unsigned PC_STEP = 4;

    localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

    // FSM encodings; the enum mirrors them for use in debug and bench code
    localparam logic [0:0] ST_RUN  = 1'b0;
    localparam logic [0:0] ST_HALT = 1'b1;

    typedef enum logic [0:0] {
        RUN  = 1'b0,
        HALT = 1'b1
    } fetch_state_t;

    typedef struct packed {
        logic [XLEN-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

    function automatic logic is_word_aligned(input logic [XLEN-1:0] addr);
        return (addr[1:0] == 2'b00);
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO of {pc, instr} pairs; flush wins over push and pop.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int unsigned  DEPTH       = 2,
    parameter int unsigned  CNT_W       = $clog2(DEPTH + 1),
    parameter fetch_entry_t RESET_ENTRY = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  fetch_entry_t     wdata,
    output fetch_entry_t     rdata,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    fetch_entry_t     mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(DEPTH));
    assign do_push = push & ~flush;
    assign do_pop  = pop & ~flush & ~empty;
    assign rdata   = mem[rd_ptr];

    // Storage is reset so the head reads a defined entry out of reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= RESET_ENTRY;
            end
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    push_when_full_a : assert property (@(posedge clk) disable iff (!rst_n)
        !(push && !flush && full && !pop));

    pop_when_empty_a : assert property (@(posedge clk) disable iff (!rst_n)
        !(pop && !flush && empty));

endmodule

// File: rtl/fetch_unit.sv
// RV32I fetch front-end: PC/credit tracking, redirect flush and response discard.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int unsigned     DEPTH    = 2
) (
    input  logic               i_clk,
    input  logic               i_rstn,
    output logic               o_imem_req,
    output logic [XLEN-1:0]    o_imem_addr,
    input  logic               i_imem_gnt,
    input  logic               i_imem_rvalid,
    input  logic [INSTR_W-1:0] i_imem_rdata,
    output logic               o_instr_valid,
    output logic [INSTR_W-1:0] o_instr,
    output logic [XLEN-1:0]    o_instr_pc,
    input  logic               i_instr_ready,
    input  logic               i_redirect,
    input  logic [XLEN-1:0]    i_redirect_pc,
    output logic               o_halt
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned SUM_W = CNT_W + 1;

    logic [0:0]       state,       state_nxt;
    logic [XLEN-1:0]  fetch_pc,    fetch_pc_nxt;
    logic [XLEN-1:0]  resp_pc,     resp_pc_nxt;
    logic [CNT_W-1:0] outstanding, outstanding_nxt;
    logic [CNT_W-1:0] discard,     discard_nxt;

    logic [CNT_W-1:0] fifo_count;
    logic             fifo_empty;
    fetch_entry_t     fifo_head;
    fetch_entry_t     fifo_wdata;

    logic             running;
    logic             redirect_act;
    logic             redirect_ok;
    logic [SUM_W-1:0] inflight;
    logic             credit_ok;
    logic             req;
    logic             grant;
    logic             keep;
    logic             drop;
    logic             instr_valid;
    logic             pop;

    // Credit counts words granted or buffered; a same-cycle pop frees nothing
    assign running      = (state == ST_RUN);
    assign redirect_act = running & i_redirect;
    assign redirect_ok  = redirect_act & is_word_aligned(i_redirect_pc);
    assign inflight     = SUM_W'(outstanding) + SUM_W'(fifo_count);
    assign credit_ok    = (inflight < SUM_W'(DEPTH));
    assign req          = i_rstn & running & ~i_redirect & credit_ok;
    assign grant        = req & i_imem_gnt;
    assign drop         = i_imem_rvalid & (discard != '0);
    assign keep         = i_imem_rvalid & (discard == '0) & running & ~i_redirect;
    assign instr_valid  = ~fifo_empty & ~i_redirect;
    assign pop          = instr_valid & i_instr_ready;

    assign fifo_wdata = '{pc: resp_pc, instr: i_imem_rdata};

    fetch_fifo #(
        .DEPTH       (DEPTH),
        .CNT_W       (CNT_W),
        .RESET_ENTRY ('{pc: RESET_PC, instr: '0})
    ) u_fifo (
        .clk   (i_clk),
        .rst_n (i_rstn),
        .push  (keep),
        .pop   (pop),
        .flush (redirect_act),
        .wdata (fifo_wdata),
        .rdata (fifo_head),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Next-state: counters follow grant/response traffic, redirect overrides
    always_comb begin
        state_nxt       = state;
        fetch_pc_nxt    = fetch_pc;
        resp_pc_nxt     = resp_pc;
        outstanding_nxt = outstanding + CNT_W'(grant) - CNT_W'(i_imem_rvalid);
        discard_nxt     = discard;

        if (grant) begin
            fetch_pc_nxt = fetch_pc + XLEN'(PC_STEP);
        end
        if (drop) begin
            discard_nxt = discard - CNT_W'(1);
        end
        if (keep) begin
            resp_pc_nxt = resp_pc + XLEN'(PC_STEP);
        end

        case (state)
            ST_RUN: begin
                if (i_redirect) begin
                    // Everything granted but not returned this cycle is stale
                    discard_nxt = outstanding - CNT_W'(i_imem_rvalid);
                    if (redirect_ok) begin
                        fetch_pc_nxt = i_redirect_pc;
                        resp_pc_nxt  = i_redirect_pc;
                    end else begin
                        state_nxt = ST_HALT;
                    end
                end
            end
            ST_HALT: begin
                state_nxt = ST_HALT;
            end
            default: begin
                state_nxt = ST_HALT;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state       <= ST_RUN;
            fetch_pc    <= RESET_PC;
            resp_pc     <= RESET_PC;
            outstanding <= '0;
            discard     <= '0;
        end else begin
            state       <= state_nxt;
            fetch_pc    <= fetch_pc_nxt;
            resp_pc     <= resp_pc_nxt;
            outstanding <= outstanding_nxt;
            discard     <= discard_nxt;
        end
    end

    assign o_imem_req    = req;
    assign o_imem_addr   = fetch_pc;
    assign o_instr_valid = instr_valid;
    assign o_instr       = fifo_head.instr;
    assign o_instr_pc    = fifo_head.pc;
    assign o_halt        = (state == ST_HALT);

    outstanding_bound_a : assert property (@(posedge i_clk) disable iff (!i_rstn)
        (outstanding <= CNT_W'(DEPTH)) && (discard <= outstanding));

    rvalid_has_grant_a : assert property (@(posedge i_clk) disable iff (!i_rstn)
        i_imem_rvalid |-> (outstanding != '0));

endmodule
